// File: rtl/store_write_buffer_if.sv
// Store, load-probe and data SRAM write signals of the store write buffer.
// Handshake: a store is taken on a clk edge with st_valid & st_ready; a write
// is retired on a clk edge with data_sram_en & data_sram_gnt and is held stable until then.
interface store_write_buffer_if;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_ade;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_gnt;

    modport master (
        output st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, data_sram_gnt,
        input  st_ready, st_ade, ld_hit, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, data_sram_gnt,
        output st_ready, st_ade, ld_hit, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/store_write_buffer.sv
// In-order store write buffer: formats SW/SH/SB into byte lanes, queues them,
// drains them to the data SRAM and flags loads that hit a pending store word.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    store_write_buffer_if.slave  bus,
    output logic                 empty,
    output logic [PTR_W:0]       count
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [29:0]      e_addr  [DEPTH];
    logic [3:0]       e_wen   [DEPTH];
    logic [31:0]      e_wdata [DEPTH];

    logic [3:0]  in_wen;
    logic [31:0] in_wdata;
    logic        in_mis;
    logic        in_legal;
    logic        enq;
    logic        deq;
    logic        hit;
    logic [PTR_W-1:0] offs;
    logic        unused_ld_low;

    assign unused_ld_low = ^bus.ld_addr[1:0];

    always_comb begin
        in_wen   = 4'b0000;
        in_wdata = bus.st_data;
        in_mis   = 1'b0;
        in_legal = 1'b1;
        case (bus.st_type)
            2'b00: begin
                in_wen = 4'b1111;
                in_mis = (bus.st_addr[1:0] != 2'b00);
            end
            2'b01: begin
                in_wen   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{bus.st_data[15:0]}};
                in_mis   = bus.st_addr[0];
            end
            2'b10: begin
                in_wen   = 4'b0001 << bus.st_addr[1:0];
                in_wdata = {4{bus.st_data[7:0]}};
            end
            default: in_legal = 1'b0;
        endcase
    end

    // Readiness comes only from registered count: no pass-through when full.
    assign bus.st_ready = (count != FULL);
    assign empty        = (count == '0);
    assign enq          = bus.st_valid & bus.st_ready & in_legal & ~in_mis;
    assign deq          = ~empty & bus.data_sram_gnt;

    // Head outputs are forced to zero when idle so stale entries never show.
    assign bus.data_sram_en    = ~empty;
    assign bus.data_sram_wen   = empty ? 4'b0000 : e_wen[rd_ptr];
    assign bus.data_sram_addr  = empty ? 32'd0 : {e_addr[rd_ptr], 2'b00};
    assign bus.data_sram_wdata = empty ? 32'd0 : e_wdata[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bus.st_ade <= 1'b0;
        end else begin
            bus.st_ade <= bus.st_valid & bus.st_ready & in_legal & in_mis;
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            e_addr[wr_ptr]  <= bus.st_addr[31:2];
            e_wen[wr_ptr]   <= in_wen;
            e_wdata[wr_ptr] <= in_wdata;
        end
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        hit  = 1'b0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if (({1'b0, offs} < count) && (e_addr[i] == bus.ld_addr[31:2])) hit = 1'b1;
        end
        if (enq && (bus.st_addr[31:2] == bus.ld_addr[31:2])) hit = 1'b1;
        bus.ld_hit = bus.ld_valid & hit;
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of the buffer.
module tb_store_write_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       empty;
  logic [2:0] count;

  store_write_buffer_if bus ();

  store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .empty (empty),
    .count (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {word addr[29:0], wen[3:0], wdata[31:0]}
  logic [65:0] exp_q[$];
  logic        exp_ade = 1'b0;
  logic        armed   = 1'b0;
  logic        last_ld_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void fmt(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                              output logic [3:0] w, output logic [31:0] wd,
                              output logic mis, output logic legal);
    w = 4'b0000; wd = d; mis = 1'b0; legal = 1'b1;
    if (t == 2'd0) begin
      w = 4'hF; mis = (a % 4) != 0;
    end else if (t == 2'd1) begin
      w = (a % 4 >= 2) ? 4'hC : 4'h3; wd = {d[15:0], d[15:0]}; mis = (a % 2) != 0;
    end else if (t == 2'd2) begin
      w = 4'(1 << (a % 4)); wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
    end else begin
      legal = 1'b0;
    end
  endfunction

  task automatic cycle(input logic v, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic ldv, input logic [31:0] lda,
                       input logic g, input logic r);
    logic [3:0]  w;
    logic [31:0] wd;
    logic        mis, legal, rdy, do_enq, do_deq, hit;
    @(negedge clk);
    bus.st_valid = v; bus.st_type = t; bus.st_addr = a; bus.st_data = d;
    bus.ld_valid = ldv; bus.ld_addr = lda; bus.data_sram_gnt = g; rst = r;
    #1;
    fmt(t, a, d, w, wd, mis, legal);
    rdy    = exp_q.size() < 4;
    do_enq = v && rdy && legal && !mis;
    do_deq = exp_q.size() > 0 && g;
    hit    = 1'b0;
    foreach (exp_q[k]) if (exp_q[k][65:36] == lda[31:2]) hit = 1'b1;
    if (do_enq && a[31:2] == lda[31:2]) hit = 1'b1;
    hit = hit && ldv;
    last_ld_hit = bus.ld_hit;
    if (armed) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("st_ready", 32'(bus.st_ready), 32'(rdy));
      check("st_ade", 32'(bus.st_ade), 32'(exp_ade));
      check("ld_hit", 32'(bus.ld_hit), 32'(hit));
      check("en", 32'(bus.data_sram_en), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("sram_addr", bus.data_sram_addr, {exp_q[0][65:36], 2'b00});
        check("sram_wen", 32'(bus.data_sram_wen), 32'(exp_q[0][35:32]));
        check("sram_wdata", bus.data_sram_wdata, exp_q[0][31:0]);
      end else begin
        check("idle_addr", bus.data_sram_addr, 32'd0);
        check("idle_wen", 32'(bus.data_sram_wen), 32'd0);
        check("idle_wdata", bus.data_sram_wdata, 32'd0);
      end
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_ade = 1'b0;
      armed   = 1'b1;
    end else begin
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq) exp_q.push_back({a[31:2], w, wd});
      exp_ade = v && rdy && legal && mis;
    end
  endtask

  task automatic idle(input logic g);
    cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0, g, 1'b0);
  endtask

  task automatic store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic g);
    cycle(1'b1, t, a, d, 1'b0, 32'd0, g, 1'b0);
  endtask

  initial begin
    logic [31:0] pool [4];
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h300;

    cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    check("rst_en", 32'(bus.data_sram_en), 32'd0);
    check("rst_ready", 32'(bus.st_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);

    // SW, then SB / SH lane formatting
    store(2'd0, 32'h100, 32'hDEADBEEF, 1'b1);
    #2;
    check("sw_en", 32'(bus.data_sram_en), 32'd1);
    check("sw_addr", bus.data_sram_addr, 32'h100);
    check("sw_wen", 32'(bus.data_sram_wen), 32'hF);
    check("sw_wdata", bus.data_sram_wdata, 32'hDEADBEEF);
    idle(1'b1);
    #2;
    check("sw_drained", 32'(empty), 32'd1);
    store(2'd2, 32'h203, 32'h000000A5, 1'b1);
    #2;
    check("sb_wen", 32'(bus.data_sram_wen), 32'h8);
    check("sb_wdata", bus.data_sram_wdata, 32'hA5A5A5A5);
    check("sb_addr", bus.data_sram_addr, 32'h200);
    store(2'd1, 32'h206, 32'h00001234, 1'b1);
    #2;
    check("sh_wen", 32'(bus.data_sram_wen), 32'hC);
    check("sh_wdata", bus.data_sram_wdata, 32'h12341234);
    idle(1'b1);

    // Fill to DEPTH, refuse the fifth, drain in order across the wrap
    for (int k = 0; k < 5; k++) store(2'd0, 32'h400 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0);
    #2;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(bus.st_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      idle(1'b0);
    end
    #2;
    check("drained_empty", 32'(empty), 32'd1);

    // Misaligned SW / SH
    store(2'd0, 32'h101, 32'h11111111, 1'b1);
    #2;
    check("ade_sw", 32'(bus.st_ade), 32'd1);
    check("ade_sw_count", 32'(count), 32'd0);
    store(2'd1, 32'h103, 32'h22222222, 1'b1);
    #2;
    check("ade_sh", 32'(bus.st_ade), 32'd1);
    check("ade_sh_count", 32'(count), 32'd0);
    idle(1'b1);

    // Load hazard detection
    store(2'd0, 32'h300, 32'h33333333, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 32'h302, 1'b0, 1'b0);
    check("hit_pending", 32'(last_ld_hit), 32'd1);
    cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 32'h304, 1'b0, 1'b0);
    check("miss_next_word", 32'(last_ld_hit), 32'd0);
    cycle(1'b1, 2'd0, 32'h304, 32'h44444444, 1'b1, 32'h304, 1'b0, 1'b0);
    check("hit_incoming", 32'(last_ld_hit), 32'd1);

    // Reset while requests are pending
    cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    check("rst_mid_en", 32'(bus.data_sram_en), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    store(2'd0, 32'h600, 32'h66666666, 1'b0);
    #2;
    check("post_rst_addr", bus.data_sram_addr, 32'h600);
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
            pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
Write-side companion to the MEM-stage load path. It accepts store requests from the EX/MEM boundary and generates byte enables and lane-replicated write data for SW/SH/SB. Accepted stores are queued in an in-order FIFO and drained to the data SRAM through a request/grant handshake. It also flags loads that hit a pending store word, so the pipeline can stall until that store has drained.

Parameters:
DEPTH  4  number of buffered stores (power of two, >=2)
PTR_W  2  log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high. Clock is clk.
st_valid  in  1  store request from pipeline
st_type  in  2  00=SW, 01=SH, 10=SB, 11=reserved (treated as no-op)
st_addr  in  32  byte address
st_data  in  32  register data (low byte/half used for SB/SH)
st_ready  out  1  buffer can accept a store this cycle
st_ade  out  1  misaligned store flagged (1-cycle pulse)
ld_valid  in  1  load in MEM stage
ld_addr  in  32  load byte address
ld_hit  out  1  load word matches a pending or incoming store
data_sram_en  out  1  write request valid
data_sram_wen  out  4  byte enables of head entry
data_sram_addr  out  32  word address of head entry, {addr[31:2],2'b00}
data_sram_wdata  out  32  lane-replicated write data of head entry
data_sram_gnt  in  1  memory accepts the current request this cycle
empty  out  1  no entries pending
count  out  PTR_W+1  number of valid entries

Behaviour:
- State: wr_ptr and rd_ptr (PTR_W bits each, wrap modulo DEPTH), count (0..DEPTH), and entry arrays {addr[31:2], wen[3:0], wdata[31:0]}.
- Reset: on a clk edge with rst=1, the pointers and count clear to 0 and all pending entries are discarded, including an in-flight head whose gnt has not arrived.
  - Cycle after reset: data_sram_en=0, data_sram_wen=0, data_sram_addr=0, data_sram_wdata=0, st_ready=1, st_ade=0, ld_hit=0, empty=1, count=0.
  - st_ade is registered and clears to 0 on reset.
- Alignment and lane formatting (combinational on the inputs):
  - SW: wen=1111, data=st_data. Misaligned if addr[1:0]!=00.
  - SH: addr[1]=0 gives wen=0011; addr[1]=1 gives wen=1100. data={2{st_data[15:0]}}. Misaligned if addr[0]=1.
  - SB: wen=0001<<addr[1:0], data={4{st_data[7:0]}}. Never misaligned.
  - Reserved type: no enqueue, no ade.
- Enqueue condition: enq = st_valid & st_ready & aligned & type!=11.
  - st_ready = (count!=DEPTH), computed from registered state only.
  - There is no same-cycle pass-through when full, even if a dequeue occurs in the same cycle.
- st_ade: registered. It is 1 in the cycle after st_valid & st_ready with a misaligned SW/SH. A misaligned store is never enqueued.
- Drain side:
  - data_sram_en = !empty. wen, addr and wdata come from entry[rd_ptr].
  - The request holds stable until granted.
  - Dequeue occurs on a clk edge with en & gnt. gnt while en=0 is ignored.
- Latency: a store enqueued at edge N into an empty buffer is presented on the SRAM port in cycle N+1. With gnt held high, one store retires per cycle.
- Simultaneous enq and deq: count is unchanged and both pointers advance. This is legal at any count between 1 and DEPTH-1. At count=DEPTH only the dequeue occurs.
- Wrap-around: pointers roll from DEPTH-1 to 0. Order is strict FIFO.
- ld_hit (combinational):
  - Asserted when ld_valid and ld_addr[31:2] equals addr[31:2] of any valid entry, including the head being granted this cycle.
  - Also asserted when it equals an incoming store with enq=1 this cycle.
  - Comparison is at word granularity; byte overlap is not refined.
  - There is no forwarding. The pipeline stalls while ld_hit=1.
- empty = (count==0).

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF with gnt=1 -> next cycle en=1, addr=0x100, wen=1111, wdata=0xDEADBEEF; the cycle after that, empty=1.
- SB addr=0x203 data=0x000000A5 -> wen=1000, wdata=0xA5A5A5A5, addr=0x200. SH addr=0x206 data=0x1234 -> wen=1100, wdata=0x12341234.
- With gnt=0, enqueue 4 stores -> count=4, st_ready=0, and a 5th store is not accepted. Then pulse gnt 4 times -> stores drain in order, with pointers wrapping through 0.
- SW addr=0x101 and SH addr=0x103 -> st_ade pulses 1 each, and count stays 0.
- With gnt=0, a pending store at 0x300 and ld_addr=0x302 -> ld_hit=1, while ld_addr=0x304 gives ld_hit=0. Same-cycle incoming store at 0x304 with ld_addr=0x304 -> ld_hit=1.
- Buffer at count=2 with gnt=0, assert rst mid-request -> next cycle en=0, count=0, and stale entries never appear afterwards.
